// File: rtl/vs_hex_word_sender_pkg.sv
// rtl/vs_hex_word_sender_pkg.sv - shared state encoding and ASCII constants for the hex word sender
// Contents: state_e (IDLE/HEX/CR/LF), ASCII_CR, ASCII_LF, counter width.
package vs_hex_word_sender_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEX  = 2'd1,
        ST_CR   = 2'd2,
        ST_LF   = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Digit counter holds NIBBLES-1, NIBBLES is at most 8.
    localparam int CNT_W = 3;

endpackage

// File: rtl/vs_hex_word_sender_if.sv
// rtl/vs_hex_word_sender_if.sv - request and character-stream bundle for the hex word sender
// Signals: start/data (word request), tx_data/tx_valid/tx_ready (character stream),
//          busy/done (status). master = sender side, slave = requester/UART side.
interface vs_hex_word_sender_if #(
    parameter int NIBBLES = 4
);
    logic                   start;
    logic [4*NIBBLES-1:0]   data;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, data, tx_ready,
        output tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, data, tx_ready,
        input  tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/vs_dc_hex_ascii.sv
// rtl/vs_dc_hex_ascii.sv - nibble to uppercase ASCII hex digit decoder
// Ports: nibble_i (4-bit value), ascii_o (0x30-0x39 for 0-9, 0x41-0x46 for A-F).
module vs_dc_hex_ascii (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);
    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = 8'h30 + {4'h0, nibble_i};
        end else begin
            // 0x37 + 0xA = 0x41 ('A')
            ascii_o = 8'h37 + {4'h0, nibble_i};
        end
    end
endmodule

// File: rtl/vs_hex_word_sender.sv
// rtl/vs_hex_word_sender.sv - prints a word as hex digits (MSB first) with optional CR/LF onto a valid/ready character stream
// Ports: clk, rst_n (async active-low), bus (vs_hex_word_sender_if.master):
//        start/data in, tx_data/tx_valid out, tx_ready in, busy/done out.
module vs_hex_word_sender
    import vs_hex_word_sender_pkg::*;
#(
    parameter int NIBBLES  = 4,
    parameter int ADD_CRLF = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vs_hex_word_sender_if.master     bus
);
    localparam int W = 4 * NIBBLES;

    state_e             state_q, state_d;
    logic [W-1:0]       shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [7:0]         hex_char;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               xfer;

    // The digit on offer is always the top nibble; shifting left exposes the next one.
    vs_dc_hex_ascii u_dec (
        .nibble_i (shift_q[W-1 -: 4]),
        .ascii_o  (hex_char)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        tx_data  = 8'h00;
        tx_valid = (state_q != ST_IDLE);
        xfer     = tx_valid && bus.tx_ready;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shift_d = bus.data;
                    cnt_d   = CNT_W'(NIBBLES - 1);
                    state_d = ST_HEX;
                end
            end
            ST_HEX: begin
                tx_data = hex_char;
                if (xfer) begin
                    if (cnt_q != '0) begin
                        shift_d = shift_q << 4;
                        cnt_d   = cnt_q - 1'b1;
                    end else if (ADD_CRLF != 0) begin
                        state_d = ST_CR;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_CR: begin
                tx_data = ASCII_CR;
                if (xfer) begin
                    state_d = ST_LF;
                end
            end
            ST_LF: begin
                tx_data = ASCII_LF;
                if (xfer) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_vs_hex_word_sender.sv
// tb/tb_vs_hex_word_sender.sv - scoreboard bench for vs_hex_word_sender (4-digit CRLF and 2-digit bare instances)
module tb_vs_hex_word_sender;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vs_hex_word_sender_if #(.NIBBLES(4)) a_if ();
    vs_hex_word_sender_if #(.NIBBLES(2)) b_if ();

    vs_hex_word_sender #(.NIBBLES(4), .ADD_CRLF(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.master)
    );

    vs_hex_word_sender #(.NIBBLES(2), .ADD_CRLF(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.master)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    logic       held_a = 1'b0;
    logic [7:0] held_a_val = 8'h00;
    logic       held_b = 1'b0;
    logic [7:0] held_b_val = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_a6(input logic [7:0] c0, c1, c2, c3, c4, c5);
        exp_a.push_back(c0); exp_a.push_back(c1); exp_a.push_back(c2);
        exp_a.push_back(c3); exp_a.push_back(c4); exp_a.push_back(c5);
    endtask

    // Monitors: compare every accepted character against the scoreboard, and
    // check a stalled character stays put until accepted.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_a = 1'b0;
        end else begin
            if (held_a) begin
                check("a_stall_valid", 32'(a_if.tx_valid), 32'd1);
                check("a_stall_data", 32'(a_if.tx_data), 32'(held_a_val));
            end
            if (a_if.tx_valid && a_if.tx_ready) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_char: got 0x%0h expected none", a_if.tx_data);
                end else begin
                    check("a_char", 32'(a_if.tx_data), 32'(exp_a.pop_front()));
                end
            end
            held_a     = a_if.tx_valid && !a_if.tx_ready;
            held_a_val = a_if.tx_data;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held_b = 1'b0;
        end else begin
            if (held_b) begin
                check("b_stall_data", 32'(b_if.tx_data), 32'(held_b_val));
            end
            if (b_if.tx_valid && b_if.tx_ready) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_char: got 0x%0h expected none", b_if.tx_data);
                end else begin
                    check("b_char", 32'(b_if.tx_data), 32'(exp_b.pop_front()));
                end
            end
            held_b     = b_if.tx_valid && !b_if.tx_ready;
            held_b_val = b_if.tx_data;
        end
    end

    // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating;
    // mode 2: ready high, plus a START with another word injected mid-send.
    // Returns at #1 after the edge that raised DONE (or after the cycle budget).
    task automatic send_a(input logic [15:0] d, input int mode,
                          output int busy_n, output int xfer_n,
                          output int done_k, output int first_k);
        busy_n  = 0;
        xfer_n  = 0;
        done_k  = -1;
        first_k = -1;
        a_if.start = 1'b1;
        a_if.data  = d;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (a_if.done) begin
                done_k = k;
                check("a_busy_low_at_done", 32'(a_if.busy), 32'd0);
                break;
            end
            case (mode)
                1: a_if.tx_ready = ((k % 3) == 0);
                2: begin
                    a_if.tx_ready = 1'b1;
                    if (k == 2) begin
                        a_if.start = 1'b1;
                        a_if.data  = 16'h5555;
                    end else if (k == 3) begin
                        a_if.start = 1'b0;
                        a_if.data  = 16'hAAAA;
                    end
                end
                default: a_if.tx_ready = 1'b1;
            endcase
            @(negedge clk);
            if (a_if.busy) busy_n++;
            if (a_if.tx_valid && first_k < 0) first_k = k;
            if (a_if.tx_valid && a_if.tx_ready) xfer_n++;
            @(posedge clk); #1;
        end
        a_if.tx_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n, xfer_n, done_k, first_k, kb;

        a_if.start = 1'b0; a_if.data = '0; a_if.tx_ready = 1'b1;
        b_if.start = 1'b0; b_if.data = '0; b_if.tx_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_valid", 32'(a_if.tx_valid), 32'd0);
        check("rst_a_busy", 32'(a_if.busy), 32'd0);
        check("rst_a_done", 32'(a_if.done), 32'd0);
        check("rst_a_data", 32'(a_if.tx_data), 32'h00);
        check("rst_b_valid", 32'(b_if.tx_valid), 32'd0);
        check("rst_b_data", 32'(b_if.tx_data), 32'h00);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready_ignored", 32'(a_if.tx_valid), 32'd0);

        // 1A2F, ready held high
        push_a6(8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A);
        send_a(16'h1A2F, 0, busy_n, xfer_n, done_k, first_k);
        check("t1_first_valid_k", 32'(first_k), 32'd0);
        check("t1_busy_cycles", 32'(busy_n), 32'd6);
        check("t1_xfers", 32'(xfer_n), 32'd6);
        check("t1_done_k", 32'(done_k), 32'd6);
        @(posedge clk); #1;
        check("t1_done_one_cycle", 32'(a_if.done), 32'd0);
        check("t1_queue_empty", 32'(exp_a.size()), 32'd0);

        // BEEF with ready 1,0,0 stalls
        push_a6(8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A);
        send_a(16'hBEEF, 1, busy_n, xfer_n, done_k, first_k);
        check("t2_xfers", 32'(xfer_n), 32'd6);
        check("t2_busy_cycles", 32'(busy_n), 32'd16);
        check("t2_done_k", 32'(done_k), 32'd16);
        @(posedge clk); #1;
        check("t2_queue_empty", 32'(exp_a.size()), 32'd0);

        // 2 digits, no CR/LF
        exp_b.push_back(8'h30);
        exp_b.push_back(8'h39);
        b_if.start = 1'b1;
        b_if.data  = 8'h09;
        @(posedge clk); #1;
        b_if.start = 1'b0;
        kb = -1;
        for (int k = 0; k < 20; k++) begin
            if (b_if.done) begin
                kb = k;
                break;
            end
            @(posedge clk); #1;
        end
        check("t3_done_k", 32'(kb), 32'd2);
        @(posedge clk); #1;
        check("t3_b_idle", 32'(b_if.busy), 32'd0);
        check("t3_queue_empty", 32'(exp_b.size()), 32'd0);

        // START for 5555 while sending 00FF is ignored
        push_a6(8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A);
        send_a(16'h00FF, 2, busy_n, xfer_n, done_k, first_k);
        check("t4_xfers", 32'(xfer_n), 32'd6);
        check("t4_done_k", 32'(done_k), 32'd6);
        @(posedge clk); #1;
        check("t4_not_restarted", 32'(a_if.busy), 32'd0);
        check("t4_queue_empty", 32'(exp_a.size()), 32'd0);

        // Reset after the second digit of 1234
        exp_a.push_back(8'h31);
        exp_a.push_back(8'h32);
        a_if.start = 1'b1;
        a_if.data  = 16'h1234;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(a_if.tx_valid), 32'd0);
        check("t5_rst_busy", 32'(a_if.busy), 32'd0);
        check("t5_rst_done", 32'(a_if.done), 32'd0);
        check("t5_rst_data", 32'(a_if.tx_data), 32'h00);
        @(negedge clk); #1;
        rst_n = 1'b1;
        check("t5_partial_consumed", 32'(exp_a.size()), 32'd0);
        push_a6(8'h43, 8'h30, 8'h44, 8'h45, 8'h0D, 8'h0A);
        send_a(16'hC0DE, 0, busy_n, xfer_n, done_k, first_k);
        check("t5_first_edge_accept", 32'(first_k), 32'd0);
        check("t5_done_k", 32'(done_k), 32'd6);
        @(posedge clk); #1;
        check("t5_queue_empty", 32'(exp_a.size()), 32'd0);

        // All 16 digits, back-to-back words started in the DONE cycle
        push_a6(8'h30, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A);
        push_a6(8'h34, 8'h35, 8'h36, 8'h37, 8'h0D, 8'h0A);
        push_a6(8'h38, 8'h39, 8'h41, 8'h42, 8'h0D, 8'h0A);
        push_a6(8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A);
        send_a(16'h0123, 0, busy_n, xfer_n, done_k, first_k);
        check("t6_w0_done_k", 32'(done_k), 32'd6);
        send_a(16'h4567, 0, busy_n, xfer_n, done_k, first_k);
        check("t6_w1_first_k", 32'(first_k), 32'd0);
        check("t6_w1_done_k", 32'(done_k), 32'd6);
        send_a(16'h89AB, 0, busy_n, xfer_n, done_k, first_k);
        check("t6_w2_done_k", 32'(done_k), 32'd6);
        send_a(16'hCDEF, 0, busy_n, xfer_n, done_k, first_k);
        check("t6_w3_done_k", 32'(done_k), 32'd6);
        @(posedge clk); #1;
        @(posedge clk); #1;

        check("final_a_queue_empty", 32'(exp_a.size()), 32'd0);
        check("final_b_queue_empty", 32'(exp_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vs_hex_word_sender.md
VS_HEX_WORD_SENDER -- requirements
Module: vs_hex_word_sender

Interface
REQ-001 Parameter NIBBLES, default 4: number of hex digits sent per word; legal range 1..8.
REQ-002 Parameter ADD_CRLF, default 1: when 1, CR (0x0D) then LF (0x0A) follow the last digit; when 0, no terminator.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 START  input  1  request to send DATA; sampled only in IDLE.
REQ-006 DATA  input  4*NIBBLES  word to print; captured on the accepted START edge.
REQ-007 TX_DATA  output  8  ASCII character offered to the UART transmitter.
REQ-008 TX_VALID  output  1  TX_DATA is valid; held until accepted.
REQ-009 TX_READY  input  1  UART transmitter can take TX_DATA this edge.
REQ-010 BUSY  output  1  high from accepted START until final character accepted.
REQ-011 DONE  output  1  one-cycle pulse after final character accepted.

Function
REQ-012 The block SHALL use a registered FSM with states IDLE, HEX, CR, LF.
REQ-013 In IDLE with START=1, the block SHALL capture DATA into a shift register, load the digit counter with NIBBLES-1, and enter HEX.
REQ-014 START in any state other than IDLE SHALL be ignored; DATA changes after capture SHALL have no effect.
REQ-015 Digits SHALL be sent most-significant nibble first; each digit maps to ASCII by 0-9 -> 0x30-0x39 and A-F -> 0x41-0x46 (uppercase).
REQ-016 TX_VALID SHALL be high in every HEX, CR and LF cycle and low in IDLE.
REQ-017 A transfer occurs on a rising edge where TX_VALID=1 and TX_READY=1; TX_DATA SHALL stay stable until then.
REQ-018 On a transfer in HEX with counter>0, the block SHALL shift the register by 4 bits and decrement the counter; the next digit is offered the following cycle.
REQ-019 On a transfer in HEX with counter=0, the next state SHALL be CR if ADD_CRLF=1, otherwise IDLE.
REQ-020 On a transfer in CR, the next state SHALL be LF; on a transfer in LF, the next state SHALL be IDLE.
REQ-021 With TX_READY held high, characters SHALL transfer on consecutive edges with no bubble; first TX_VALID appears the cycle after the START edge.
REQ-022 TX_READY while TX_VALID=0 SHALL be ignored; TX_READY low for any number of cycles SHALL stall without loss or duplication.
REQ-023 BUSY SHALL equal (state != IDLE).
REQ-024 DONE SHALL be registered, high for exactly the one cycle following the final transfer, and otherwise low.
REQ-025 A START in the cycle DONE is high SHALL be accepted normally. Back-to-back words SHALL therefore have one idle cycle between them.
REQ-026 Total transfers per word SHALL be NIBBLES + 2*ADD_CRLF.

Reset
REQ-027 RST_N low SHALL immediately force state IDLE, TX_VALID=0, BUSY=0, DONE=0, TX_DATA=0x00, counter and shift register to 0, including mid-word.
REQ-028 After RST_N deasserts, the block SHALL accept START on the first rising edge.

Structure
REQ-029 State encodings and the constants ASCII_CR=0x0D and ASCII_LF=0x0A SHALL live in the shared UART package/header.
REQ-030 The nibble-to-ASCII conversion SHALL be one instance of the existing VS_DC_HEX_ASCII decoder, fed by the top nibble of the shift register. TX_DATA SHALL be muxed among the decoder output, ASCII_CR and ASCII_LF.

Verification
REQ-031 NIBBLES=4, ADD_CRLF=1, DATA=16'h1A2F, TX_READY=1 -> TX_DATA 0x31,0x41,0x32,0x46,0x0D,0x0A on 6 consecutive edges; DONE high 1 cycle; BUSY high 6 cycles.
REQ-032 DATA=16'hBEEF, TX_READY toggling 1,0,0,1,... -> same 0x42,0x45,0x45,0x46,0x0D,0x0A order; TX_DATA stable across every stall.
REQ-033 NIBBLES=2, ADD_CRLF=0, DATA=8'h09 -> exactly 0x30,0x39; then DONE; no CR/LF.
REQ-034 START pulsed with DATA=16'h5555 while busy sending 16'h00FF -> output 0x30,0x30,0x46,0x46,0x0D,0x0A only.
REQ-035 RST_N low after the second digit of 16'h1234 -> TX_VALID, BUSY low immediately. A new START with 16'hC0DE then yields 0x43,0x30,0x44,0x45,0x0D,0x0A.
REQ-036 Sweep all 16 digit values (DATA=16'h0123, 16'h4567, 16'h89AB, 16'hCDEF) -> each digit matches REQ-015 mapping.
